// File: rtl/fft_ctrl_pkg.sv
// Shared widths and one-hot state encoding for the FFT output-side controller.
package fft_ctrl_pkg;

  localparam int unsigned DEF_BUSWIDTH  = 12;
  localparam int unsigned DEF_DATAWIDTH = 16;
  localparam int unsigned DEF_EXPWIDTH  = 6;
  localparam int unsigned DEF_NFWIDTH   = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WAIT_SOP = 4'b0010,
    ST_DATA     = 4'b0100,
    ST_DONE     = 4'b1000
  } state_e;

endpackage

// File: rtl/fft_ctrl_edge_det.sv
// Registered rising-edge detector; the edge is a combinational AND of two flops.
module fft_ctrl_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_c_o
);

  logic sig_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      prev_q <= sig_q;
    end
  end

  assign rise_c_o = sig_q & ~prev_q;

endmodule

// File: rtl/fft_ctrl_out.sv
// FFT output sink: checks Avalon-ST framing, forwards bins to the output FIFO
// and captures a programmed number of frames per START.
module fft_ctrl_out
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned BUSWIDTH  = DEF_BUSWIDTH,
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned EXPWIDTH  = DEF_EXPWIDTH,
  parameter int unsigned NFWIDTH   = DEF_NFWIDTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [BUSWIDTH-1:0]    FRAMELENGTH,
  input  logic [NFWIDTH-1:0]     NUMFRAMES,
  input  logic                   sink_valid,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic [1:0]             sink_error,
  input  logic [DATAWIDTH-1:0]   sink_real,
  input  logic [DATAWIDTH-1:0]   sink_imag,
  input  logic [EXPWIDTH-1:0]    sink_exp,
  output logic                   sink_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic [2*DATAWIDTH-1:0] fifo_data,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FRAME_ERR,
  output logic [NFWIDTH-1:0]     FRAMES_DONE,
  output logic [EXPWIDTH-1:0]    LAST_EXP
);

  localparam int unsigned CW = BUSWIDTH + 1;

  state_e                 state_q, state_d;
  logic [BUSWIDTH-1:0]    flen_q, flen_d;
  logic [NFWIDTH-1:0]     nf_q, nf_d;
  logic [CW-1:0]          bincnt_q, bincnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [NFWIDTH-1:0]     fdone_q, fdone_d;
  logic [EXPWIDTH-1:0]    lexp_q, lexp_d;
  logic                   wr_q, wr_d;
  logic [2*DATAWIDTH-1:0] data_q, data_d;

  logic                   start_rise;
  logic                   accept;
  logic                   eop_hit;
  logic [CW-1:0]          cnt_next;
  logic [NFWIDTH-1:0]     fdone_next;

  fft_ctrl_edge_det u_start_edge (
    .clk      (CLK),
    .rst_n    (RST_N),
    .sig_i    (START),
    .rise_c_o (start_rise)
  );

  assign sink_ready = ((state_q == ST_WAIT_SOP) || (state_q == ST_DATA)) && !fifo_full;
  assign accept     = sink_valid && sink_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      flen_q   <= '0;
      nf_q     <= '0;
      bincnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fdone_q  <= '0;
      lexp_q   <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      flen_q   <= flen_d;
      nf_q     <= nf_d;
      bincnt_q <= bincnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fdone_q  <= fdone_d;
      lexp_q   <= lexp_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flen_d     = flen_q;
    nf_d       = nf_q;
    bincnt_d   = bincnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    fdone_d    = fdone_q;
    lexp_d     = lexp_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    eop_hit    = 1'b0;
    cnt_next   = bincnt_q;
    fdone_next = fdone_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          flen_d  = FRAMELENGTH;
          nf_d    = (NUMFRAMES == '0) ? NFWIDTH'(1) : NUMFRAMES;
          err_d   = 1'b0;
          fdone_d = '0;
          busy_d  = 1'b1;
          state_d = ST_WAIT_SOP;
        end
      end
      ST_WAIT_SOP: begin
        if (accept) begin
          if (sink_error != 2'b00) err_d = 1'b1;
          if (!sink_sop) begin
            err_d = 1'b1;
          end else begin
            wr_d     = 1'b1;
            data_d   = {sink_imag, sink_real};
            cnt_next = CW'(1);
            bincnt_d = cnt_next;
            state_d  = ST_DATA;
            eop_hit  = sink_eop;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (sink_error != 2'b00) err_d = 1'b1;
          wr_d   = 1'b1;
          data_d = {sink_imag, sink_real};
          // A mid-frame sop restarts the bin count rather than dropping the beat
          if (sink_sop) begin
            err_d    = 1'b1;
            cnt_next = CW'(1);
          end else begin
            cnt_next = bincnt_q + CW'(1);
          end
          bincnt_d = cnt_next;
          eop_hit  = sink_eop;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame close: DONE is raised together with the write of the final beat
    if (eop_hit) begin
      if (cnt_next != {1'b0, flen_q}) err_d = 1'b1;
      lexp_d     = sink_exp;
      fdone_next = fdone_q + NFWIDTH'(1);
      fdone_d    = fdone_next;
      if (fdone_next == nf_q) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = ST_WAIT_SOP;
      end
    end
  end

  assign fifo_wr     = wr_q;
  assign fifo_data   = data_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign FRAME_ERR   = err_q;
  assign FRAMES_DONE = fdone_q;
  assign LAST_EXP    = lexp_q;

endmodule

// File: tb/tb_fft_ctrl_out.sv
// Randomised bench for fft_ctrl_out with a frame-level reference model and
// a write scoreboard drained by an independent monitor.
module tb_fft_ctrl_out;

  localparam int unsigned BW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned EW = 6;
  localparam int unsigned NW = 8;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            START;
  logic [BW-1:0]   FRAMELENGTH;
  logic [NW-1:0]   NUMFRAMES;
  logic            sink_valid, sink_sop, sink_eop;
  logic [1:0]      sink_error;
  logic [DW-1:0]   sink_real, sink_imag;
  logic [EW-1:0]   sink_exp;
  logic            sink_ready;
  logic            fifo_full;
  logic            fifo_wr;
  logic [2*DW-1:0] fifo_data;
  logic            BUSY, DONE, FRAME_ERR;
  logic [NW-1:0]   FRAMES_DONE;
  logic [EW-1:0]   LAST_EXP;

  fft_ctrl_out dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .FRAMELENGTH(FRAMELENGTH),
    .NUMFRAMES(NUMFRAMES), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_error(sink_error), .sink_real(sink_real),
    .sink_imag(sink_imag), .sink_exp(sink_exp), .sink_ready(sink_ready),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .BUSY(BUSY), .DONE(DONE), .FRAME_ERR(FRAME_ERR),
    .FRAMES_DONE(FRAMES_DONE), .LAST_EXP(LAST_EXP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            done;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;

  // Reference model: 0 = not capturing, 1 = expecting sop, 2 = inside a frame
  int            m_state = 0;
  int            m_len = 0, m_nf = 0, m_cnt = 0, m_fd = 0, m_dones = 0;
  bit            m_err = 0;
  logic [EW-1:0] m_exp = '0;
  bit            rnd_bp = 0;
  bit            rnd_gap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return (m_state != 0) && !fifo_full;
  endfunction

  task automatic model_accept(input bit sop, input bit eop, input logic [1:0] err,
                              input logic [DW-1:0] re, input logic [DW-1:0] im,
                              input logic [EW-1:0] ex);
    bit fin;
    fin = 0;
    if (err != 2'b00) m_err = 1;
    if (m_state == 1 && !sop) begin
      m_err = 1;
      return;
    end
    if (sop) begin
      if (m_state == 2) m_err = 1;
      m_cnt = 1;
    end else begin
      m_cnt++;
    end
    m_state = 2;
    if (eop) begin
      if ((m_cnt % (1 << (BW + 1))) != m_len) m_err = 1;
      m_exp = ex;
      m_fd++;
      if (m_fd == m_nf) begin
        fin = 1;
        m_state = 0;
        m_dones++;
      end else begin
        m_state = 1;
      end
    end
    sb_q.push_back('{data: {im, re}, done: fin});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_beat(input bit sop, input bit eop, input logic [1:0] err, input int hold);
    logic [DW-1:0] re, im;
    logic [EW-1:0] ex;
    bit ok;
    @(negedge CLK);
    re = DW'($urandom);
    im = DW'($urandom);
    ex = EW'($urandom);
    sink_valid = 1; sink_sop = sop; sink_eop = eop; sink_error = err;
    sink_real = re; sink_imag = im; sink_exp = ex;
    for (int h = 0; h < hold; h++) begin
      fifo_full = 1;
      #1 chk("ready_low_when_full", sink_ready, 1'b0);
      @(negedge CLK);
    end
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      fifo_full = rnd_bp && ($urandom_range(0, 3) == 0);
      #1 chk("sink_ready", sink_ready, exp_ready());
      if (sink_ready) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
      sink_valid = 0; fifo_full = 0;
      return;
    end
    model_accept(sop, eop, err, re, im, ex);
    @(posedge CLK);
    #1;
    sink_valid = 0; sink_sop = 0; sink_eop = 0; sink_error = 0; fifo_full = 0;
  endtask

  task automatic send_frame(input int n, input int restart_at, input bit rnd_err);
    for (int i = 0; i < n; i++) begin
      logic [1:0] e;
      e = (rnd_err && $urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive_beat(i == 0 || i == restart_at, i == n - 1, e, 0);
      if (rnd_gap && $urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  task automatic start_cap(input int len, input int nf);
    @(negedge CLK);
    FRAMELENGTH = BW'(len);
    NUMFRAMES   = NW'(nf);
    START = 1;
    repeat (3) @(negedge CLK);
    START = 0;
    m_state = 1; m_len = len; m_nf = (nf == 0) ? 1 : nf;
    m_err = 0; m_fd = 0; m_cnt = 0;
    chk("busy_after_start", BUSY, 1'b1);
  endtask

  task automatic check_status(input string tag);
    idle(4);
    chk({tag, ".sb_empty"}, sb_q.size(), 0);
    chk({tag, ".frame_err"}, FRAME_ERR, m_err);
    chk({tag, ".frames_done"}, FRAMES_DONE, m_fd);
    chk({tag, ".last_exp"}, LAST_EXP, m_exp);
    chk({tag, ".busy"}, BUSY, m_state != 0);
    chk({tag, ".done_pulses"}, done_cnt, m_dones);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".fifo_wr"}, fifo_wr, 1'b0);
    chk({tag, ".fifo_data"}, fifo_data, '0);
    chk({tag, ".done"}, DONE, 1'b0);
    chk({tag, ".busy"}, BUSY, 1'b0);
    chk({tag, ".frame_err"}, FRAME_ERR, 1'b0);
    chk({tag, ".frames_done"}, FRAMES_DONE, '0);
    chk({tag, ".last_exp"}, LAST_EXP, '0);
    chk({tag, ".sink_ready"}, sink_ready, 1'b0);
  endtask

  // Monitor: every FIFO write must match the next expected bin
  always @(posedge CLK) begin
    sb_t e;
    #1;
    if (fifo_wr) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write actual=%0h required=none t=%0t", fifo_data, $time);
      end else begin
        e = sb_q.pop_front();
        chk("fifo_data", fifo_data, e.data);
        chk("done_with_last_write", DONE, e.done);
      end
    end else if (DONE) begin
      total++; bad++;
      $display("FAIL done_without_write actual=1 required=0 t=%0t", $time);
    end
    if (DONE) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1; START = 0; FRAMELENGTH = '0; NUMFRAMES = '0;
    sink_valid = 0; sink_sop = 0; sink_eop = 0; sink_error = 0;
    sink_real = '0; sink_imag = '0; sink_exp = '0; fifo_full = 0;
    #2 RST_N = 0;
    idle(3);
    check_reset_outputs("por");
    RST_N = 1;
    idle(2);

    // Two clean frames with random backpressure
    start_cap(8, 2);
    rnd_bp = 1;
    send_frame(8, -1, 0);
    send_frame(8, -1, 0);
    check_status("nominal");
    rnd_bp = 0;

    // FIFO full held three cycles mid-frame with valid high
    start_cap(8, 1);
    for (int i = 0; i < 8; i++) drive_beat(i == 0, i == 7, 2'b00, (i == 4) ? 3 : 0);
    check_status("backpressure");

    // Short frame
    start_cap(8, 1);
    send_frame(6, -1, 0);
    check_status("len_err");
    chk("len_err.flag", FRAME_ERR, 1'b1);

    // Stray beat before sop, then a restart followed by exactly 8 beats
    start_cap(8, 1);
    drive_beat(0, 0, 2'b00, 0);
    send_frame(11, 3, 0);
    check_status("protocol");

    // START edge during a capture must not re-arm
    start_cap(8, 2);
    send_frame(8, -1, 0);
    @(negedge CLK);
    FRAMELENGTH = BW'(3); NUMFRAMES = NW'(1); START = 1;
    idle(3);
    START = 0;
    send_frame(8, -1, 0);
    check_status("start_busy");
    chk("start_busy.frames", FRAMES_DONE, NW'(2));

    // NUMFRAMES = 0 captures a single frame, then the sink stalls
    start_cap(4, 0);
    send_frame(4, -1, 0);
    check_status("nf_zero");
    @(negedge CLK);
    sink_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ready_after_done", sink_ready, 1'b0);
      @(negedge CLK);
    end
    sink_valid = 0;

    // FRAMELENGTH = 0 is always a length error
    start_cap(0, 1);
    send_frame(2, -1, 0);
    check_status("len_zero");

    // Single-beat frames: sop and eop on the same beat
    start_cap(1, 2);
    send_frame(1, -1, 0);
    send_frame(1, -1, 0);
    check_status("len_one");

    // Reset during beat 4 abandons the frame
    start_cap(8, 1);
    for (int i = 0; i < 4; i++) drive_beat(i == 0, 0, 2'b00, 0);
    @(negedge CLK);
    RST_N = 0;
    #1 check_reset_outputs("mid_reset");
    sb_q.delete();
    m_state = 0; m_err = 0; m_fd = 0; m_exp = '0; m_cnt = 0;
    idle(2);
    RST_N = 1;
    idle(2);
    start_cap(8, 1);
    send_frame(8, -1, 0);
    check_status("after_reset");

    // Random captures with mixed lengths, errors, restarts and stalls
    rnd_bp = 1;
    rnd_gap = 1;
    for (int r = 0; r < 8; r++) begin
      int len, nf, eff, n, rs;
      len = $urandom_range(1, 10);
      nf  = $urandom_range(0, 3);
      eff = (nf == 0) ? 1 : nf;
      start_cap(len, nf);
      for (int f = 0; f < eff; f++) begin
        if ($urandom_range(0, 4) == 0) drive_beat(0, 0, 2'b00, 0);
        n  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : len;
        rs = (n > 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
        send_frame(n, rs, 1);
      end
      check_status("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_ctrl_out.md
Name: fft_ctrl_out

Overview:
Sink-side controller at the FFT core output, the counterpart of the input-side framer. It accepts the core's Avalon-ST output frames (sop/eop/valid/ready), checks framing against the programmed frame length, and writes each bin into the post-FFT output FIFO with backpressure. It captures a fixed number of frames per START, then reports completion, frame errors and the last block exponent.

Parameters:
BUSWIDTH, 12, width of FRAMELENGTH; the bin counter is BUSWIDTH+1 bits
DATAWIDTH, 16, width of each real/imag sample
EXPWIDTH, 6, width of the FFT block exponent
NFWIDTH, 8, width of NUMFRAMES and FRAMES_DONE

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  level; its rising edge arms a capture
FRAMELENGTH  in  BUSWIDTH  expected bins per frame, latched at arm
NUMFRAMES  in  NFWIDTH  frames to capture per arm, latched at arm; 0 is treated as 1
sink_valid  in  1  FFT output beat valid
sink_sop  in  1  start of packet
sink_eop  in  1  end of packet
sink_error  in  2  core error code; nonzero is an error
sink_real  in  DATAWIDTH  real part
sink_imag  in  DATAWIDTH  imaginary part
sink_exp  in  EXPWIDTH  block exponent
sink_ready  out  1  backpressure to the FFT core
fifo_full  in  1  output-FIFO almost-full; must assert with at least 1 free slot
fifo_wr  out  1  FIFO write strobe
fifo_data  out  2*DATAWIDTH  {imag, real}
BUSY  out  1  high from arm until DONE
DONE  out  1  one-cycle pulse when the capture completes
FRAME_ERR  out  1  sticky error flag, cleared at arm
FRAMES_DONE  out  NFWIDTH  frames completed in the current capture
LAST_EXP  out  EXPWIDTH  sink_exp latched on the last accepted eop beat

Behaviour:
- Reset (RST_N low, async): state IDLE; fifo_wr, fifo_data, DONE, BUSY, FRAME_ERR, FRAMES_DONE and LAST_EXP all 0; START edge register 0.
- START is registered once. The rising edge is detected as START_reg=1 with prev=0. A START edge while not in IDLE is ignored.
- sink_ready is combinational: it equals (state is WAIT_SOP or DATA) and not fifo_full. It is 0 in IDLE and DONE.
- A beat is accepted when sink_valid and sink_ready are both high. An accepted, written beat produces fifo_wr=1 with fifo_data={imag, real} on the next cycle (latency 1). Otherwise fifo_wr=0.
- IDLE: on a START edge, latch FRAMELENGTH and NUMFRAMES (0 becomes 1), clear FRAME_ERR and FRAMES_DONE, set BUSY=1, go to WAIT_SOP.
- WAIT_SOP:
  - Accepted beat with sop=0: discarded (no write), FRAME_ERR set.
  - Accepted beat with sop=1: written, bincnt set to 1, go to DATA.
  - If the sop beat also has eop=1: handle it as the eop case in DATA, using bincnt=1 for the length check.
- DATA:
  - Each accepted beat is written and bincnt increments.
  - Accepted beat with sop=1 (restart): FRAME_ERR set, the beat is written, bincnt reset to 1, stay in DATA.
  - Accepted eop beat: if the final count (bincnt after this beat) is not equal to {1'b0, FRAMELENGTH}, set FRAME_ERR. Latch LAST_EXP, increment FRAMES_DONE. If FRAMES_DONE reaches NUMFRAMES go to DONE, else go to WAIT_SOP.
  - Beats beyond FRAMELENGTH without eop keep being written; the error is flagged at eop.
- In any accepting state, an accepted beat with sink_error nonzero sets FRAME_ERR.
- DONE: assert DONE for 1 cycle, clear BUSY, return to IDLE. DONE coincides with the registered write of the final beat.
- Arithmetic: bincnt is BUSWIDTH+1 bits and wraps silently. FRAMELENGTH=0 is illegal and yields FRAME_ERR on every eop.
- fifo_full asserted mid-frame: sink_ready drops the same cycle. No beat is lost and the frame resumes when fifo_full deasserts.
- Reset mid-frame: immediate return to IDLE. The partial frame is abandoned and no DONE pulse is produced.

Decomposition:
- Package fft_ctrl_pkg: one-hot state constants (IDLE, WAIT_SOP, DATA, DONE) and the default widths BUSWIDTH, DATAWIDTH, EXPWIDTH, NFWIDTH.
- One sub-module, fft_ctrl_edge_det: registered rising-edge detector with async active-low reset, used for START.

Test Plan:
- Nominal: FRAMELENGTH=8, NUMFRAMES=2, START, two clean 8-beat frames -> 16 fifo_wr in order; FRAMES_DONE=2; DONE one pulse; FRAME_ERR=0; LAST_EXP equals the exp on the second eop.
- Backpressure: fifo_full held high for 3 cycles mid-frame while sink_valid stays high -> sink_ready=0 on those cycles, no writes, all 8 bins written exactly once in order.
- Length error: FRAMELENGTH=8, frame ends with eop at beat 6 -> 6 writes, FRAME_ERR=1, FRAMES_DONE=1.
- Protocol errors: beat without sop in WAIT_SOP -> not written, FRAME_ERR=1. sop in mid-frame -> bincnt restarts, a frame of exactly 8 following the restart completes with FRAMES_DONE incremented.
- START handling: START edge while BUSY -> no effect; NUMFRAMES=0 -> exactly one frame captured then DONE.
- Reset: RST_N low at beat 4 of a frame -> all outputs 0 asynchronously; after release and a new START, a clean frame completes with FRAME_ERR=0.
